// File: rtl/io_led_seg_ctrl_pkg.sv
// Shared constants for the LED / seven-segment output peripheral.
// Register offsets are byte offsets inside the 16-byte window.
package io_pkg;

   localparam logic [31:0] IO_BASE_DEFAULT = 32'hFFFF_FC60;
   localparam int unsigned NUM_DIGITS      = 8;
   localparam logic [7:0]  SEG_BLANK       = 8'hFF;

   typedef enum logic [3:0] {
      OFF_LED_LO = 4'h0,
      OFF_LED_HI = 4'h2,
      OFF_SEG_LO = 4'h4,
      OFF_SEG_HI = 4'h6,
      OFF_SEG_EN = 4'h8,
      OFF_SEG_DP = 4'hA
   } reg_off_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Hex nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}.
// Lowercase b and d keep them distinct from 8 and 0.
module seg7_hex_decode (
   input  logic [3:0] nibble,
   output logic [6:0] segs
);

   always_comb begin
      segs = 7'h00;
      case (nibble)
         4'h0: segs = 7'h3F;
         4'h1: segs = 7'h06;
         4'h2: segs = 7'h5B;
         4'h3: segs = 7'h4F;
         4'h4: segs = 7'h66;
         4'h5: segs = 7'h6D;
         4'h6: segs = 7'h7D;
         4'h7: segs = 7'h07;
         4'h8: segs = 7'h7F;
         4'h9: segs = 7'h6F;
         4'hA: segs = 7'h77;
         4'hB: segs = 7'h7C;
         4'hC: segs = 7'h39;
         4'hD: segs = 7'h5E;
         4'hE: segs = 7'h79;
         4'hF: segs = 7'h71;
         default: segs = 7'h00;
      endcase
   end

endmodule

// File: rtl/io_led_seg_ctrl.sv
// Memory-mapped LED and 8-digit multiplexed seven-segment output peripheral.
// Display outputs are registered from the current digit index, so they trail it by one clock.
module io_led_seg_ctrl
   import io_pkg::*;
#(
   parameter logic [31:0] IO_BASE  = IO_BASE_DEFAULT,
   parameter int unsigned SCAN_DIV = 50000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        led_ctrl,
   input  logic [31:0] addr,
   input  logic [15:0] wdata,
   output logic [23:0] led_out,
   output logic [7:0]  seg_an,
   output logic [7:0]  seg_out
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

   logic [15:0]   led_lo;
   logic [7:0]    led_hi;
   logic [15:0]   seg_lo;
   logic [15:0]   seg_hi;
   logic [7:0]    seg_en;
   logic [7:0]    seg_dp;
   logic [PW-1:0] presc;
   logic [2:0]    digit_idx;

   logic          hit;
   reg_off_e      offset;
   logic [31:0]   seg_word;
   logic [3:0]    nibble;
   logic [6:0]    segs;

   // addr[0] is dropped: halfword stores to an odd byte address hit the same register
   assign hit      = led_ctrl && (addr[31:4] == IO_BASE[31:4]);
   assign offset   = reg_off_e'({addr[3:1], 1'b0});
   assign seg_word = {seg_hi, seg_lo};
   assign nibble   = seg_word[{digit_idx, 2'b00} +: 4];
   assign led_out  = {led_hi, led_lo};

   seg7_hex_decode u_hex_decode (
      .nibble (nibble),
      .segs   (segs)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         led_lo    <= '0;
         led_hi    <= '0;
         seg_lo    <= '0;
         seg_hi    <= '0;
         seg_en    <= '0;
         seg_dp    <= '0;
         presc     <= '0;
         digit_idx <= '0;
         seg_an    <= SEG_BLANK;
         seg_out   <= SEG_BLANK;
      end else begin
         if (hit) begin
            case (offset)
               OFF_LED_LO: led_lo <= wdata;
               OFF_LED_HI: led_hi <= wdata[7:0];
               OFF_SEG_LO: seg_lo <= wdata;
               OFF_SEG_HI: seg_hi <= wdata;
               OFF_SEG_EN: seg_en <= wdata[7:0];
               OFF_SEG_DP: seg_dp <= wdata[7:0];
               default: ;
            endcase
         end

         if (presc == PRESC_LAST) begin
            presc     <= '0;
            digit_idx <= digit_idx + 3'd1;
         end else begin
            presc <= presc + 1'b1;
         end

         if (seg_en[digit_idx]) begin
            seg_an  <= ~(8'b1 << digit_idx);
            seg_out <= {~seg_dp[digit_idx], ~segs};
         end else begin
            seg_an  <= SEG_BLANK;
            seg_out <= SEG_BLANK;
         end
      end
   end

endmodule

// File: tb/tb_io_led_seg_ctrl.sv
// Directed self-checking bench for io_led_seg_ctrl with a 4-cycle digit slot.
`timescale 1ns/1ps
module tb_io_led_seg_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        led_ctrl = 1'b0;
   logic [31:0] addr = '0;
   logic [15:0] wdata = '0;
   logic [23:0] led_out;
   logic [7:0]  seg_an;
   logic [7:0]  seg_out;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   // Glyphs for digits '0'..'7' and 'C','D','E','F','8','9','A','b', dp off
   logic [7:0] exp_dec [8] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
   logic [7:0] exp_hex [8] = '{8'hC6, 8'hA1, 8'h86, 8'h8E, 8'h80, 8'h90, 8'h88, 8'h83};

   io_led_seg_ctrl #(
      .IO_BASE  (32'hFFFF_FC60),
      .SCAN_DIV (4)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .led_ctrl (led_ctrl),
      .addr     (addr),
      .wdata    (wdata),
      .led_out  (led_out),
      .seg_an   (seg_an),
      .seg_out  (seg_out)
   );

   always #5 clock = ~clock;

   task automatic bus_write(input logic [31:0] a, input logic [15:0] d);
      @(negedge clock);
      led_ctrl = 1'b1;
      addr     = a;
      wdata    = d;
      @(negedge clock);
      led_ctrl = 1'b0;
   endtask

   // Leaves the bench at the negedge where seg_an first shows `cur` right after `prev`.
   task automatic wait_transition(input logic [7:0] prev, input logic [7:0] cur, input string tag);
      logic [7:0] last;
      bit found = 0;
      last = seg_an;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         if (last == prev && seg_an == cur) found = 1;
         last = seg_an;
      end
      if (!found) begin
         vectors++;
         miscompares++;
         $display("FAIL %s sync: no %h->%h transition seen, last seg_an=%h", tag, prev, cur, seg_an);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      vectors++;
      if (led_out !== 24'h0) begin
         miscompares++; $display("FAIL reset led_out: got %h want %h", led_out, 24'h0);
      end
      vectors++;
      if (seg_an !== 8'hFF) begin
         miscompares++; $display("FAIL reset seg_an: got %h want %h", seg_an, 8'hFF);
      end
      vectors++;
      if (seg_out !== 8'hFF) begin
         miscompares++; $display("FAIL reset seg_out: got %h want %h", seg_out, 8'hFF);
      end
      reset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         vectors++;
         if (seg_an !== 8'hFF || seg_out !== 8'hFF) begin
            miscompares++;
            $display("FAIL idle_blank cyc%0d: got an=%h seg=%h want an=FF seg=FF", i, seg_an, seg_out);
         end
      end
   endtask

   task automatic test_led_write();
      bus_write(32'hFFFF_FC60, 16'hA5C3);
      vectors++;
      if (led_out !== 24'h00A5C3) begin
         miscompares++; $display("FAIL led_lo: got %h want %h", led_out, 24'h00A5C3);
      end
      bus_write(32'hFFFF_FC62, 16'h12F0);
      vectors++;
      if (led_out !== 24'hF0A5C3) begin
         miscompares++; $display("FAIL led_hi: got %h want %h", led_out, 24'hF0A5C3);
      end
      bus_write(32'hFFFF_FC70, 16'hFFFF);
      vectors++;
      if (led_out !== 24'hF0A5C3) begin
         miscompares++; $display("FAIL led_miss_addr: got %h want %h", led_out, 24'hF0A5C3);
      end
      @(negedge clock);
      addr = 32'hFFFF_FC60; wdata = 16'h0000;
      @(negedge clock);
      vectors++;
      if (led_out !== 24'hF0A5C3) begin
         miscompares++; $display("FAIL led_no_cs: got %h want %h", led_out, 24'hF0A5C3);
      end
   endtask

   task automatic test_scan();
      bus_write(32'hFFFF_FC64, 16'h3210);
      bus_write(32'hFFFF_FC66, 16'h7654);
      bus_write(32'hFFFF_FC6A, 16'h0000);
      bus_write(32'hFFFF_FC68, 16'h00FF);
      wait_transition(8'h7F, 8'hFE, "scan");
      for (int i = 0; i < 36; i++) begin
         int d;
         logic [7:0] e_an;
         if (i > 0) @(negedge clock);
         d = (i / 4) % 8;
         e_an = ~(8'b1 << d);
         vectors++;
         if (seg_an !== e_an || seg_out !== exp_dec[d]) begin
            miscompares++;
            $display("FAIL scan cyc%0d digit%0d: got an=%h seg=%h want an=%h seg=%h",
                     i, d, seg_an, seg_out, e_an, exp_dec[d]);
         end
      end
   endtask

   task automatic test_blank_dp();
      bus_write(32'hFFFF_FC6A, 16'h0004);
      bus_write(32'hFFFF_FC68, 16'h0005);
      wait_transition(8'hFF, 8'hFE, "blank");
      for (int i = 0; i < 32; i++) begin
         int d;
         logic [7:0] e_an, e_seg;
         if (i > 0) @(negedge clock);
         d = i / 4;
         if (d == 0) begin
            e_an = 8'hFE; e_seg = 8'hC0;
         end else if (d == 2) begin
            e_an = 8'hFB; e_seg = 8'h24;
         end else begin
            e_an = 8'hFF; e_seg = 8'hFF;
         end
         vectors++;
         if (seg_an !== e_an || seg_out !== e_seg) begin
            miscompares++;
            $display("FAIL blank_dp cyc%0d digit%0d: got an=%h seg=%h want an=%h seg=%h",
                     i, d, seg_an, seg_out, e_an, e_seg);
         end
      end
   endtask

   task automatic test_hex_glyphs();
      bus_write(32'hFFFF_FC6A, 16'h0000);
      bus_write(32'hFFFF_FC64, 16'hFEDC);
      bus_write(32'hFFFF_FC66, 16'hBA98);
      bus_write(32'hFFFF_FC68, 16'h00FF);
      wait_transition(8'h7F, 8'hFE, "hex");
      for (int i = 0; i < 32; i++) begin
         int d;
         logic [7:0] e_an;
         if (i > 0) @(negedge clock);
         d = i / 4;
         e_an = ~(8'b1 << d);
         vectors++;
         if (seg_an !== e_an || seg_out !== exp_hex[d]) begin
            miscompares++;
            $display("FAIL hex cyc%0d digit%0d: got an=%h seg=%h want an=%h seg=%h",
                     i, d, seg_an, seg_out, e_an, exp_hex[d]);
         end
      end
   endtask

   task automatic test_midop_reset();
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clock);
         if (seg_an == 8'hDF) found = 1;
      end
      if (!found) begin
         vectors++; miscompares++;
         $display("FAIL midreset sync: digit 5 never shown, seg_an=%h", seg_an);
      end
      reset = 1'b1; led_ctrl = 1'b1; addr = 32'hFFFF_FC60; wdata = 16'h1234;
      @(negedge clock);
      vectors++;
      if (led_out !== 24'h0 || seg_an !== 8'hFF || seg_out !== 8'hFF) begin
         miscompares++;
         $display("FAIL midreset outputs: got led=%h an=%h seg=%h want led=000000 an=FF seg=FF",
                  led_out, seg_an, seg_out);
      end
      // Release and enable all digits on the first post-reset edge
      reset = 1'b0; addr = 32'hFFFF_FC68; wdata = 16'h00FF;
      @(negedge clock);
      led_ctrl = 1'b0;
      vectors++;
      if (seg_an !== 8'hFF) begin
         miscompares++; $display("FAIL midreset first_edge an: got %h want %h", seg_an, 8'hFF);
      end
      for (int i = 0; i < 7; i++) begin
         logic [7:0] e_an;
         @(negedge clock);
         e_an = (i < 3) ? 8'hFE : 8'hFD;
         vectors++;
         if (seg_an !== e_an || seg_out !== 8'hC0) begin
            miscompares++;
            $display("FAIL midreset restart cyc%0d: got an=%h seg=%h want an=%h seg=C0",
                     i, seg_an, seg_out, e_an);
         end
      end
      vectors++;
      if (led_out !== 24'h0) begin
         miscompares++; $display("FAIL midreset dropped_write: got %h want %h", led_out, 24'h0);
      end
   endtask

   initial begin
      test_reset();
      test_led_write();
      test_scan();
      test_blank_dp();
      test_hex_glyphs();
      test_midop_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
